// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package axi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping to 0.
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    int w_j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        w_j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[w_j]) begin
                any = 1'b1;
                idx = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_REQ valid/ready streams into one
// registered output slot.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       vld_in,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]       last_in,
    output logic [NUM_REQ-1:0]       rdy_in,
    output logic                     vld_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     last_out,
    output logic [ID_W-1:0]          id_out,
    input  logic                     rdy_out
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W-1:0]  r_lock_id;
    logic [ID_W-1:0]  w_lock_nxt;

    logic             r_vld;
    logic             r_last;
    logic [WIDTH-1:0] r_data;
    logic [ID_W-1:0]  r_id;

    logic             w_load_en;
    logic             w_any;
    logic [ID_W-1:0]  w_pick;
    logic [ID_W-1:0]  w_gnt;
    logic             w_xfer;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] g);
        if (int'(g) == NUM_REQ - 1) begin
            return '0;
        end
        return ID_W'(int'(g) + 1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (vld_in),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    // The slot may take a new beat whenever it is empty or draining this cycle.
    assign w_load_en = !r_vld || rdy_out;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_id;
        w_gnt       = r_lock_id;
        rdy_in      = '0;
        if (!rst) begin
            unique case (r_state)
                ARB_IDLE: begin
                    w_gnt = w_pick;
                    if (w_load_en && w_any) begin
                        rdy_in[w_pick] = 1'b1;
                        if (last_in[w_pick]) begin
                            w_ptr_nxt = next_idx(w_pick);
                        end else begin
                            w_state_nxt = ARB_LOCK;
                            w_lock_nxt  = w_pick;
                        end
                    end
                end
                ARB_LOCK: begin
                    rdy_in[r_lock_id] = w_load_en;
                    if (w_load_en && vld_in[r_lock_id] && last_in[r_lock_id]) begin
                        w_state_nxt = ARB_IDLE;
                        w_ptr_nxt   = next_idx(r_lock_id);
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    assign w_xfer = |(rdy_in & vld_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_lock_id <= '0;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
            r_id      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_nxt;
            if (w_load_en) begin
                r_vld <= w_xfer;
                if (w_xfer) begin
                    r_data <= data_in[int'(w_gnt)*WIDTH +: WIDTH];
                    r_last <= last_in[w_gnt];
                    r_id   <= w_gnt;
                end
            end
        end
    end

    assign vld_out  = r_vld;
    assign data_out = r_data;
    assign last_out = r_last;
    assign id_out   = r_id;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Randomized bench for axi_rr_arbiter against a cycle-level reference model
// built from per-requester beat queues.
module tb_axi_rr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   vld_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   last_in;
    logic [N-1:0]   rdy_in;
    logic           vld_out;
    logic [W-1:0]   data_out;
    logic           last_out;
    logic [IW-1:0]  id_out;
    logic           rdy_out;

    axi_rr_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .last_in  (last_in),
        .rdy_in   (rdy_in),
        .vld_out  (vld_out),
        .data_out (data_out),
        .last_out (last_out),
        .id_out   (id_out),
        .rdy_out  (rdy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           l;
    } beat_t;

    beat_t        pq[N][$];
    bit           active[N];
    int           pop_cnt[N];
    int           obs_id[$];
    int           obs_d[$];

    int           n_checks = 0;
    int           n_errors = 0;

    // Reference model: ptr, owner (-1 when not inside a packet) and the slot.
    int           m_ptr;
    int           m_owner;
    bit           m_vld;
    bit           m_last;
    logic [W-1:0] m_data;
    int           m_id;

    int           rdy_pct;
    int           gate_pct;
    bit           rst_ctl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic enq(input int r, input int d, input bit l);
        beat_t b;
        b.d = W'(d);
        b.l = l;
        pq[r].push_back(b);
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_d.delete();
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        bit           load_en;
        int           g;
        int           j;
        @(negedge clk);
        check_eq("vld_out", 32'(vld_out), 32'(m_vld));
        if (m_vld) begin
            check_eq("data_out", 32'(data_out), 32'(m_data));
            check_eq("last_out", 32'(last_out), 32'(m_last));
            check_eq("id_out", 32'(id_out), 32'(m_id));
        end
        rst     = rst_ctl;
        rdy_out = ($urandom_range(99) < rdy_pct);
        for (int i = 0; i < N; i++) begin
            if (!active[i] && pq[i].size() > 0 && $urandom_range(99) < gate_pct) begin
                active[i] = 1'b1;
            end
            vld_in[i] = active[i];
            if (active[i]) begin
                data_in[i*W +: W] = pq[i][0].d;
                last_in[i]        = pq[i][0].l;
            end else begin
                data_in[i*W +: W] = W'($urandom);
                last_in[i]        = 1'($urandom_range(1));
            end
        end
        if (vld_out && rdy_out) begin
            obs_id.push_back(int'(id_out));
            obs_d.push_back(int'(data_out));
        end
        #1;
        load_en = !m_vld || rdy_out;
        exp_rdy = '0;
        g       = -1;
        if (!rst_ctl && load_en) begin
            if (m_owner >= 0) begin
                exp_rdy[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && active[j]) begin
                        g          = j;
                        exp_rdy[j] = 1'b1;
                    end
                end
            end
        end
        check_eq("rdy_in", 32'(rdy_in), 32'(exp_rdy));
        if (rst_ctl) begin
            m_vld   = 1'b0;
            m_data  = '0;
            m_last  = 1'b0;
            m_id    = 0;
            m_ptr   = 0;
            m_owner = -1;
            for (int i = 0; i < N; i++) begin
                pq[i].delete();
                active[i] = 1'b0;
            end
        end else begin
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i] && active[i]) g = i;
            end
            if (load_en) m_vld = (g >= 0);
            if (g >= 0) begin
                m_data = pq[g][0].d;
                m_last = pq[g][0].l;
                m_id   = g;
                if (pq[g][0].l) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % N;
                end else begin
                    m_owner = g;
                end
                void'(pq[g].pop_front());
                active[g] = 1'b0;
                pop_cnt[g]++;
            end
        end
    endtask

    task automatic expect_first_id(input string tag, input int exp);
        if (obs_id.size() == 0) begin
            check_eq(tag, 32'hFFFF_FFFF, 32'(exp));
        end else begin
            check_eq(tag, 32'(obs_id[0]), 32'(exp));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        logic [W-1:0] exp_d[8];
        int exp_id[8];

        vld_in   = '0;
        data_in  = '0;
        last_in  = '0;
        rdy_out  = 1'b0;
        rst      = 1'b1;
        rst_ctl  = 1'b1;
        rdy_pct  = 100;
        gate_pct = 100;
        m_owner  = -1;
        m_ptr    = 0;
        m_vld    = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i]  = 1'b0;
            pop_cnt[i] = 0;
        end

        step();
        step();
        check_eq("rst_vld_out", 32'(vld_out), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_last_out", 32'(last_out), 32'd0);
        check_eq("rst_id_out", 32'(id_out), 32'd0);
        check_eq("rst_rdy_in", 32'(rdy_in), 32'd0);
        rst_ctl = 1'b0;

        // Fairness: single-beat packets from everybody.
        clear_obs();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) enq(i, 'hA0 + i, 1'b1);
        end
        repeat (16) step();
        for (int k = 0; k < 8; k++) begin
            if (k < obs_id.size()) begin
                check_eq("fair_id", 32'(obs_id[k]), 32'(k % N));
                check_eq("fair_data", 32'(obs_d[k]), 32'('hA0 + k % N));
            end else begin
                check_eq("fair_count", 32'(obs_id.size()), 32'(k + 1));
            end
        end

        // Packet lock: req1 three beats while req2 waits.
        clear_obs();
        enq(1, 'h11, 1'b0);
        enq(1, 'h12, 1'b0);
        enq(1, 'h13, 1'b1);
        enq(2, 'h22, 1'b1);
        repeat (10) step();
        exp_d  = '{'h11, 'h12, 'h13, 'h22, 0, 0, 0, 0};
        exp_id = '{1, 1, 1, 2, 0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            if (k < obs_id.size()) begin
                check_eq("lock_id", 32'(obs_id[k]), 32'(exp_id[k]));
                check_eq("lock_data", 32'(obs_d[k]), 32'(exp_d[k]));
            end else begin
                check_eq("lock_count", 32'(obs_id.size()), 32'(k + 1));
            end
        end

        // Backpressure: stalled output slot.
        enq(0, 'h05, 1'b1);
        enq(0, 'h06, 1'b1);
        rdy_pct = 0;
        repeat (5) step();
        rdy_pct = 100;
        repeat (4) step();

        // Reset in the middle of a 4-beat req3 packet.
        base = pop_cnt[3];
        for (int b = 0; b < 4; b++) enq(3, 'h31 + b, b == 3);
        cnt = 0;
        while (pop_cnt[3] < base + 2 && cnt < 20) begin
            step();
            cnt++;
        end
        check_eq("midpkt_progress", 32'(pop_cnt[3] - base), 32'd2);
        rst_ctl = 1'b1;
        step();
        rst_ctl = 1'b0;
        clear_obs();
        enq(0, 'h0F, 1'b1);
        enq(3, 'h3F, 1'b1);
        repeat (5) step();
        expect_first_id("post_rst_first", 0);

        // Wrap: req3 alone moves ptr back to 0.
        enq(3, 'h3A, 1'b1);
        repeat (4) step();
        clear_obs();
        enq(0, 'h0A, 1'b1);
        enq(3, 'h3B, 1'b1);
        repeat (5) step();
        expect_first_id("wrap_first", 0);

        // Idle period, then ptr=2 decides between req1 and req2.
        repeat (10) step();
        enq(1, 'h1A, 1'b1);
        repeat (4) step();
        clear_obs();
        enq(1, 'h1B, 1'b1);
        enq(2, 'h2B, 1'b1);
        repeat (5) step();
        expect_first_id("idle_ptr2_first", 2);

        // Random traffic with gaps, backpressure and occasional reset.
        gate_pct = 60;
        rdy_pct  = 70;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 30) begin
                int r;
                int len;
                r   = int'($urandom_range(N - 1));
                len = int'($urandom_range(4, 1));
                if (pq[r].size() < 8) begin
                    for (int b = 0; b < len; b++) enq(r, int'($urandom), b == len - 1);
                end
            end
            rst_ctl = ($urandom_range(499) == 0);
            step();
        end
        rst_ctl = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Merges NUM_REQ valid/ready producer streams into one valid/ready stream, typically the input of an axi_fifo that feeds a shared rasterizer stage.
- Round-robin arbitration at packet granularity: once a requester is granted, it holds the output until it sends a beat with last_in set.
- Single registered output slot, so the downstream path has one cycle of latency at full throughput.

Parameters:
- WIDTH, 64, data bits per beat.
- NUM_REQ, 4, number of requesters (1 or more).
- ID_W, $clog2(NUM_REQ) with a minimum of 1, width of the source-ID field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high; one clock, all logic on the rising edge of clk.
- vld_in  in  NUM_REQ  per-requester beat valid.
- data_in  in  NUM_REQ*WIDTH  per-requester data; requester i occupies [i*WIDTH +: WIDTH].
- last_in  in  NUM_REQ  per-requester end-of-packet flag.
- rdy_in  out  NUM_REQ  per-requester ready; at most one bit high.
- vld_out  out  1  output beat valid.
- data_out  out  WIDTH  output data.
- last_out  out  1  output end-of-packet flag.
- id_out  out  ID_W  index of the requester that sourced the output beat.
- rdy_out  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - vld_out, data_out, last_out and id_out are cleared to 0.
  - Round-robin pointer ptr is set to 0 and state goes to IDLE.
  - rdy_in is forced to 0 while rst is high.
- Output slot load enable: load_en = !vld_out | rdy_out. The slot is refilled in the same cycle it drains, so steady state is one beat per cycle.
- Transfers:
  - An input beat transfers when vld_in[g] & rdy_in[g].
  - The transferred beat is registered into the slot (data, last, id=g) and vld_out is 1 the next cycle.
  - vld_out drops only when the slot drains with no new beat loaded.
- rdy_in[i] may depend combinationally on vld_in and rdy_out. vld_out, data_out, last_out and id_out never depend combinationally on inputs.
- Output beats follow the valid/ready rule: while vld_out=1 and rdy_out=0, data_out, last_out and id_out hold stable.
- IDLE state:
  - If load_en and any vld_in bit is set: grant g = first i with vld_in[i], searching ptr, ptr+1, … with wrap to 0. Set rdy_in[g]=load_en.
  - If the granted beat has last_in[g]=1: stay in IDLE and set ptr = (g+1) mod NUM_REQ.
  - If last_in[g]=0: go to LOCK with lock_id=g. ptr does not change yet.
  - No valid requester, or load_en=0: no grant, ptr unchanged.
- LOCK state:
  - rdy_in[lock_id]=load_en; all other rdy_in bits are 0. Other requesters' vld_in are ignored for as long as the packet lasts (no timeout).
  - On transfer of a beat with last_in=1: go to IDLE and set ptr = (lock_id+1) mod NUM_REQ.
  - A gap in vld_in[lock_id] keeps the lock.
- Wrap-around: ptr wraps from NUM_REQ-1 to 0. With NUM_REQ=1, ptr stays 0 and arbitration degenerates to pass-through with one register stage.
- Reset mid-packet:
  - The lock is dropped and any beat held in the slot is discarded (vld_out=0).
  - Packet integrity is the upstream's responsibility after reset.
  - The first grant after reset uses ptr=0.
- Producer rule: a producer must hold data_in and last_in stable while its vld_in is high and not yet accepted. The arbiter does not check this.

Decomposition:
- Package axi_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCK}.
  - function id_width(n) returning max(1, $clog2(n)).
- Sub-module rr_pick (combinational): inputs req[NUM_REQ] and ptr[ID_W]; outputs any and idx[ID_W], the first set bit at or after ptr with wrap.
- The top level holds the state register, ptr, lock_id and the output slot.

Test Plan (NUM_REQ=4, WIDTH=16):
1. Fairness: all four vld_in held high, single-beat packets (last_in=1) with data 0xA0+i, rdy_out=1 → from cycle 2, one beat per cycle; id_out sequence 0,1,2,3,0,1…; data_out 0xA0,0xA1,0xA2,0xA3,…
2. Packet lock: req1 sends 3 beats 0x11, 0x12, 0x13 (last on the third) while req2 holds valid with 0x22 → output 0x11, 0x12, 0x13 contiguous with id_out=1; rdy_in[2]=0 throughout; 0x22 (id 2) follows on the next cycle.
3. Backpressure: req0 valid with 0x05, 0x06, rdy_out=0 for 5 cycles → exactly one beat loaded; vld_out=1 with data_out=0x05 stable; rdy_in=0 after the first accept; when rdy_out rises, 0x06 appears the next cycle.
4. Reset mid-packet: assert rst after beat 2 of a 4-beat req3 packet → next cycle vld_out=0 and rdy_in=0; after release with req0 and req3 both valid, req0 is granted first.
5. Wrap: only req3 sends one single-beat packet (ptr becomes 0), then req0 and req3 both valid → req0 granted.
6. Idle: no vld_in for 10 cycles → vld_out is 0 after the slot drains and ptr is unchanged; then req1 and req2 valid with ptr=2 → req2 granted before req1.
